// File: rtl/dma_guard_pkg.sv
// ---------------------------------------------------------------------------
// dma_guard_pkg
// Shared definitions for the DMA region guard:
//   state_t  - guard FSM encoding (KILL, WAIT, RUN)
//   MODE_RD  - mode bit index that blocks DMA reads
//   MODE_WR  - mode bit index that blocks DMA writes
//   CNT_W    - width of the KILL hold counter
// ---------------------------------------------------------------------------
package dma_guard_pkg;

    typedef enum logic [1:0] {
        KILL = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int MODE_RD = 0;
    localparam int MODE_WR = 1;
    localparam int CNT_W   = 8;

endpackage

// File: rtl/dma_region_match.sv
// ---------------------------------------------------------------------------
// dma_region_match
// Single protected-region comparator.
// Ports:
//   base  (in,  ADDR_W) region start address
//   size  (in,  ADDR_W) region size in bytes, 0 disables the region
//   mode  (in,  2)      bit0 blocks reads, bit1 blocks writes
//   addr  (in,  ADDR_W) DMA address
//   en    (in,  1)      DMA access valid
//   we    (in,  1)      DMA write (1) / read (0)
//   viol  (out, 1)      access hits the region with a blocked direction
// ---------------------------------------------------------------------------
module dma_region_match
    import dma_guard_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] size,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    input  logic              we,
    output logic              viol
);

    // End address is one bit wider so a region reaching the top of the
    // address space does not wrap to zero and match nothing.
    logic [ADDR_W:0] end_addr;
    logic            hit;
    logic            blocked;

    assign end_addr = {1'b0, base} + {1'b0, size};
    assign hit      = en && (size != '0) && (addr >= base) && ({1'b0, addr} < end_addr);
    assign blocked  = we ? mode[MODE_WR] : mode[MODE_RD];
    assign viol     = hit && blocked;

endmodule

// File: rtl/dma_region_guard.sv
// ---------------------------------------------------------------------------
// dma_region_guard
// Watches DMA traffic against NUM_REGIONS protected windows. A blocked access
// holds the CPU in reset (kill_rst) for at least HOLD_CYCLES cycles, then
// waits for the PC to reach RESET_HANDLER before releasing.
// Ports:
//   clk       (in,  1)           system clock
//   reset_n   (in,  1)           asynchronous active-low reset
//   pc        (in,  ADDR_W)      current program counter
//   dma_addr  (in,  ADDR_W)      DMA address
//   dma_en    (in,  1)           DMA access valid
//   dma_we    (in,  1)           DMA write (1) / read (0)
//   kill_rst  (out, 1)           registered CPU reset request
//   viol_addr (out, ADDR_W)      first violating address  [DMA_GUARD_CAPTURE_EN]
//   viol_we   (out, 1)           first violating direction [DMA_GUARD_CAPTURE_EN]
//   viol_map  (out, NUM_REGIONS) sticky per-region violation flags
// Optional feature macro: DMA_GUARD_CAPTURE_EN (violation capture registers).
// ---------------------------------------------------------------------------
module dma_region_guard
    import dma_guard_pkg::*;
#(
    parameter int                            ADDR_W        = 16,
    parameter int                            NUM_REGIONS   = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE   = {16'hA000, 16'h0400},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE   = {16'h2000, 16'h0C00},
    parameter logic [NUM_REGIONS*2-1:0]      REGION_MODE   = {2'b10, 2'b11},
    parameter int                            HOLD_CYCLES   = 4,
    parameter logic [ADDR_W-1:0]             RESET_HANDLER = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      pc,
    input  logic [ADDR_W-1:0]      dma_addr,
    input  logic                   dma_en,
    input  logic                   dma_we,
    output logic                   kill_rst,
`ifdef DMA_GUARD_CAPTURE_EN
    output logic [ADDR_W-1:0]      viol_addr,
    output logic                   viol_we,
`endif
    output logic [NUM_REGIONS-1:0] viol_map
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_REGIONS-1:0] viol_vec;
    logic                   viol;
    logic                   run_entry;

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        dma_region_match #(
            .ADDR_W (ADDR_W)
        ) u_match (
            .base (REGION_BASE[i*ADDR_W +: ADDR_W]),
            .size (REGION_SIZE[i*ADDR_W +: ADDR_W]),
            .mode (REGION_MODE[i*2 +: 2]),
            .addr (dma_addr),
            .en   (dma_en),
            .we   (dma_we),
            .viol (viol_vec[i])
        );
    end

    assign viol = |viol_vec;

    // The only release path; a violation in WAIT takes priority over release.
    assign run_entry = (state == WAIT) && !viol && (pc == RESET_HANDLER);

    // kill_rst is assigned alongside every state change so it always reflects
    // the state being entered, giving one cycle from a RUN violation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= KILL;
            cnt      <= '0;
            kill_rst <= 1'b1;
        end else begin
            case (state)
                KILL: begin
                    kill_rst <= 1'b1;
                    if (viol) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (viol) begin
                        state    <= KILL;
                        cnt      <= '0;
                        kill_rst <= 1'b1;
                    end else if (pc == RESET_HANDLER) begin
                        state    <= RUN;
                        kill_rst <= 1'b0;
                    end
                end
                RUN: begin
                    if (viol) begin
                        state    <= KILL;
                        cnt      <= '0;
                        kill_rst <= 1'b1;
                    end
                end
                default: begin
                    state    <= KILL;
                    cnt      <= '0;
                    kill_rst <= 1'b1;
                end
            endcase
        end
    end

    // Sticky flags: cleared on release, new violations OR'd in so set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol_map <= '0;
        end else begin
            viol_map <= (run_entry ? '0 : viol_map) | viol_vec;
        end
    end

`ifdef DMA_GUARD_CAPTURE_EN
    // Holds the first offender until the next release.
    logic cap_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_valid <= 1'b0;
            viol_addr <= '0;
            viol_we   <= 1'b0;
        end else if (run_entry) begin
            cap_valid <= 1'b0;
            viol_addr <= '0;
            viol_we   <= 1'b0;
        end else if (viol && !cap_valid) begin
            cap_valid <= 1'b1;
            viol_addr <= dma_addr;
            viol_we   <= dma_we;
        end
    end
`else
    // Default build carries no capture state.
`endif

endmodule

// File: tb/tb_dma_region_guard.sv
// ---------------------------------------------------------------------------
// tb_dma_region_guard
// Directed bench for dma_region_guard. A second instance uses regions that
// end at the top of the address space and overlap each other.
// ---------------------------------------------------------------------------
module tb_dma_region_guard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic [15:0] dma_addr;
    logic        dma_en;
    logic        dma_we;
    logic        kill_rst;
    logic [1:0]  viol_map;
    logic        kill2;
    logic [1:0]  map2;
`ifdef DMA_GUARD_CAPTURE_EN
    logic [15:0] viol_addr;
    logic        viol_we;
    logic [15:0] viol_addr2;
    logic        viol_we2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_region_guard u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc        (pc),
        .dma_addr  (dma_addr),
        .dma_en    (dma_en),
        .dma_we    (dma_we),
        .kill_rst  (kill_rst),
`ifdef DMA_GUARD_CAPTURE_EN
        .viol_addr (viol_addr),
        .viol_we   (viol_we),
`endif
        .viol_map  (viol_map)
    );

    // Region 0: F000..FFFF blocks both; region 1: E000..FFFF blocks reads.
    dma_region_guard #(
        .NUM_REGIONS (2),
        .REGION_BASE ({16'hE000, 16'hF000}),
        .REGION_SIZE ({16'h2000, 16'h1000}),
        .REGION_MODE ({2'b01, 2'b11})
    ) u_dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc        (pc),
        .dma_addr  (dma_addr),
        .dma_en    (dma_en),
        .dma_we    (dma_we),
        .kill_rst  (kill2),
`ifdef DMA_GUARD_CAPTURE_EN
        .viol_addr (viol_addr2),
        .viol_we   (viol_we2),
`endif
        .viol_map  (map2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [15:0] a, input logic w);
        dma_en   = 1'b1;
        dma_addr = a;
        dma_we   = w;
    endtask

    // Ticks until the selected instance drops kill_rst; n is the tick count.
    task automatic wait_run(input int which, input int budget, output int n);
        n = 0;
        dma_en = 1'b0;
        while (((which == 0) ? kill_rst : kill2) !== 1'b0) begin
            if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL wait_run%0d timeout got %0d cycles want <= %0d", which, n, budget);
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (kill_rst !== 1'b1) begin errors++; $display("FAIL rst_kill got %b want 1", kill_rst); end
        checks++;
        if (viol_map !== 2'b00) begin errors++; $display("FAIL rst_map got %b want 00", viol_map); end
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (kill_rst !== 1'b1) begin errors++; $display("FAIL rst_hold%0d got %b want 1", i, kill_rst); end
        end
        tick();
        checks++;
        if (kill_rst !== 1'b0) begin errors++; $display("FAIL rst_release got %b want 0", kill_rst); end
        checks++;
        if (viol_map !== 2'b00) begin errors++; $display("FAIL rst_map_run got %b want 00", viol_map); end
        checks++;
        if (kill2 !== 1'b0) begin errors++; $display("FAIL rst_release2 got %b want 0", kill2); end
    endtask

    task automatic test_region0();
        int n;
        access(16'h03FF, 1'b0);
        tick();
        checks++;
        if (kill_rst !== 1'b0 || viol_map !== 2'b00) begin
            errors++; $display("FAIL r0_below got kill=%b map=%b want kill=0 map=00", kill_rst, viol_map);
        end
        access(16'h0FFF, 1'b0);
        tick();
        checks++;
        if (kill_rst !== 1'b1 || viol_map !== 2'b01) begin
            errors++; $display("FAIL r0_top got kill=%b map=%b want kill=1 map=01", kill_rst, viol_map);
        end
        dma_en = 1'b0;
        tick();
        checks++;
        if (kill_rst !== 1'b1 || viol_map !== 2'b01) begin
            errors++; $display("FAIL r0_hold got kill=%b map=%b want kill=1 map=01", kill_rst, viol_map);
        end
        wait_run(0, 20, n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL r0_len got %0d want 4", n); end
        checks++;
        if (viol_map !== 2'b00) begin errors++; $display("FAIL r0_clear got %b want 00", viol_map); end
        access(16'h1000, 1'b0);
        tick();
        checks++;
        if (kill_rst !== 1'b0 || viol_map !== 2'b00) begin
            errors++; $display("FAIL r0_past got kill=%b map=%b want kill=0 map=00", kill_rst, viol_map);
        end
        dma_en = 1'b0;
    endtask

    task automatic test_region1();
        int n;
        access(16'hA010, 1'b0);
        tick();
        checks++;
        if (kill_rst !== 1'b0 || viol_map !== 2'b00) begin
            errors++; $display("FAIL r1_read got kill=%b map=%b want kill=0 map=00", kill_rst, viol_map);
        end
        access(16'hA010, 1'b1);
        tick();
        checks++;
        if (kill_rst !== 1'b1 || viol_map !== 2'b10) begin
            errors++; $display("FAIL r1_write got kill=%b map=%b want kill=1 map=10", kill_rst, viol_map);
        end
        wait_run(0, 20, n);
        checks++;
        if (n != 5) begin errors++; $display("FAIL r1_len got %0d want 5", n); end
        access(16'hC000, 1'b1);
        tick();
        checks++;
        if (kill_rst !== 1'b0) begin errors++; $display("FAIL r1_past got %b want 0", kill_rst); end
        access(16'hBFFF, 1'b1);
        tick();
        checks++;
        if (kill_rst !== 1'b1 || viol_map !== 2'b10) begin
            errors++; $display("FAIL r1_top got kill=%b map=%b want kill=1 map=10", kill_rst, viol_map);
        end
        wait_run(0, 20, n);
    endtask

    task automatic test_wrap_overlap();
        int n;
        access(16'hDFFF, 1'b0);
        tick();
        checks++;
        if (kill2 !== 1'b0 || map2 !== 2'b00) begin
            errors++; $display("FAIL ov_below got kill=%b map=%b want kill=0 map=00", kill2, map2);
        end
        access(16'hF800, 1'b0);
        tick();
        checks++;
        if (kill2 !== 1'b1 || map2 !== 2'b11) begin
            errors++; $display("FAIL ov_both got kill=%b map=%b want kill=1 map=11", kill2, map2);
        end
        wait_run(1, 20, n);
        checks++;
        if (n != 5 || map2 !== 2'b00) begin
            errors++; $display("FAIL ov_release got n=%0d map=%b want n=5 map=00", n, map2);
        end
        access(16'hFFFF, 1'b0);
        tick();
        checks++;
        if (map2 !== 2'b11) begin errors++; $display("FAIL ov_ffff got %b want 11", map2); end
        wait_run(1, 20, n);
        access(16'hE000, 1'b1);
        tick();
        checks++;
        if (kill2 !== 1'b0) begin errors++; $display("FAIL ov_wr_e000 got %b want 0", kill2); end
        access(16'hE000, 1'b0);
        tick();
        checks++;
        if (map2 !== 2'b10) begin errors++; $display("FAIL ov_rd_e000 got %b want 10", map2); end
        wait_run(1, 20, n);
        access(16'hF000, 1'b1);
        tick();
        checks++;
        if (map2 !== 2'b01) begin errors++; $display("FAIL ov_wr_f000 got %b want 01", map2); end
        wait_run(1, 20, n);
    endtask

    task automatic test_kill_restart();
        int n;
        access(16'h0500, 1'b0);
        tick();
        dma_en = 1'b0;
        tick();
        tick();
        access(16'h0500, 1'b0);
        tick();
        wait_run(0, 20, n);
        checks++;
        if (n != 5) begin errors++; $display("FAIL kr_restart got %0d want 5", n); end
        access(16'h0500, 1'b0);
        tick();
        dma_en = 1'b0;
        pc     = 16'h1234;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (kill_rst !== 1'b1) begin errors++; $display("FAIL kr_wait_pc got %b want 1", kill_rst); end
        pc = 16'h0000;
        access(16'h0500, 1'b0);
        tick();
        checks++;
        if (kill_rst !== 1'b1) begin errors++; $display("FAIL kr_wait_viol got %b want 1", kill_rst); end
        wait_run(0, 20, n);
        checks++;
        if (n != 5) begin errors++; $display("FAIL kr_wait_len got %0d want 5", n); end
    endtask

    task automatic test_async_reset();
        int n;
        reset_n = 1'b0;
        #2;
        checks++;
        if (kill_rst !== 1'b1) begin errors++; $display("FAIL ar_kill got %b want 1", kill_rst); end
        #1;
        reset_n = 1'b1;
        wait_run(0, 20, n);
        checks++;
        if (n != 5) begin errors++; $display("FAIL ar_len got %0d want 5", n); end
        access(16'h0500, 1'b0);
        tick();
        dma_en  = 1'b0;
        reset_n = 1'b0;
        #2;
        checks++;
        if (viol_map !== 2'b00 || kill_rst !== 1'b1) begin
            errors++; $display("FAIL ar_map got kill=%b map=%b want kill=1 map=00", kill_rst, viol_map);
        end
        #1;
        reset_n = 1'b1;
        wait_run(0, 20, n);
        checks++;
        if (n != 5) begin errors++; $display("FAIL ar_len2 got %0d want 5", n); end
    endtask

`ifdef DMA_GUARD_CAPTURE_EN
    task automatic test_capture();
        int n;
        checks++;
        if (viol_addr !== 16'h0000) begin errors++; $display("FAIL cap_init got %h want 0000", viol_addr); end
        access(16'h0500, 1'b0);
        tick();
        checks++;
        if (viol_addr !== 16'h0500 || viol_we !== 1'b0) begin
            errors++; $display("FAIL cap_first got %h/%b want 0500/0", viol_addr, viol_we);
        end
        access(16'h0600, 1'b1);
        tick();
        checks++;
        if (viol_addr !== 16'h0500 || viol_we !== 1'b0) begin
            errors++; $display("FAIL cap_keep got %h/%b want 0500/0", viol_addr, viol_we);
        end
        wait_run(0, 20, n);
        checks++;
        if (viol_addr !== 16'h0000 || viol_we !== 1'b0) begin
            errors++; $display("FAIL cap_clear got %h/%b want 0000/0", viol_addr, viol_we);
        end
        access(16'h0700, 1'b1);
        tick();
        checks++;
        if (viol_addr !== 16'h0700 || viol_we !== 1'b1) begin
            errors++; $display("FAIL cap_again got %h/%b want 0700/1", viol_addr, viol_we);
        end
        wait_run(0, 20, n);
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        pc       = 16'h0000;
        dma_addr = 16'h0000;
        dma_en   = 1'b0;
        dma_we   = 1'b0;
        test_reset();
        test_region0();
        test_region1();
        test_wrap_overlap();
        test_kill_restart();
        test_async_reset();
`ifdef DMA_GUARD_CAPTURE_EN
        test_capture();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_region_guard.md
DMA_REGION_GUARD -- requirements
Module: dma_region_guard

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: PC and DMA address width.
REQ-002 SHALL have parameter NUM_REGIONS, default 2: number of protected regions, range 1..8.
REQ-003 SHALL have parameter REGION_BASE, default {16'hA000,16'h0400}: flattened NUM_REGIONS*ADDR_W region base addresses, region 0 in the LSBs.
REQ-004 SHALL have parameter REGION_SIZE, default {16'h2000,16'h0C00}: flattened region sizes in bytes; size 0 disables the region.
REQ-005 SHALL have parameter REGION_MODE, default {2'b10,2'b11}: flattened 2-bit modes per region; bit0 blocks DMA reads, bit1 blocks DMA writes.
REQ-006 SHALL have parameter HOLD_CYCLES, default 4: minimum cycles in KILL, range 1..255.
REQ-007 SHALL have parameter RESET_HANDLER, default 16'h0000: PC value that releases the guard.
REQ-008 SHALL have port clk, input, 1: system clock.
REQ-009 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-010 SHALL have port pc, input, ADDR_W: current program counter.
REQ-011 SHALL have port dma_addr, input, ADDR_W: DMA address.
REQ-012 SHALL have port dma_en, input, 1: DMA access valid this cycle.
REQ-013 SHALL have port dma_we, input, 1: DMA access is a write when high, a read when low.
REQ-014 SHALL have port kill_rst, output, 1: reset request to the CPU, active high.
REQ-015 SHALL have port viol_map, output, NUM_REGIONS: sticky per-region violation flags.

Function
REQ-016 SHALL flag region i hit when dma_en=1, REGION_SIZE[i]!=0, and REGION_BASE[i] <= dma_addr < REGION_BASE[i]+REGION_SIZE[i], with the end computed in ADDR_W+1 bits so a region ending at 2^ADDR_W does not wrap.
REQ-017 SHALL flag region i violated when it is hit and the mode bit matching dma_we is set; viol = OR of all region violations.
REQ-018 SHALL implement three states: KILL, WAIT and RUN.
REQ-019 In KILL, SHALL increment the hold counter each cycle and go to WAIT when the counter equals HOLD_CYCLES-1; a violation in KILL SHALL clear the counter to 0.
REQ-020 In WAIT, a violation SHALL go to KILL with counter 0; otherwise pc==RESET_HANDLER SHALL go to RUN; otherwise it SHALL stay in WAIT.
REQ-021 In RUN, a violation SHALL go to KILL with counter 0 in the next cycle.
REQ-022 kill_rst SHALL be a registered output, high in every cycle in which the state is not RUN; from a RUN-cycle violation to kill_rst=1 the latency SHALL be 1 cycle.
REQ-023 viol_map[i] SHALL set on the cycle after a region-i violation, SHALL hold through KILL and WAIT, and SHALL clear on the WAIT->RUN transition.
REQ-024 When a set and a clear occur in the same cycle, the set SHALL win.
REQ-025 Simultaneous hits in several regions SHALL set every corresponding viol_map bit.

Reset
REQ-026 reset_n low SHALL immediately force state KILL, counter 0, kill_rst=1, viol_map=0, and capture registers 0.
REQ-027 Deassertion mid-operation SHALL restart the KILL hold sequence; there SHALL be no bypass to RUN.

Configuration
REQ-028 With macro DMA_GUARD_CAPTURE_EN defined, the block SHALL add outputs viol_addr (ADDR_W) and viol_we (1), which latch dma_addr and dma_we of the first violation since the last entry to RUN; later violations SHALL NOT overwrite them until the next WAIT->RUN transition clears them.
REQ-029 Without DMA_GUARD_CAPTURE_EN, those ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package dma_guard_pkg SHALL hold the state encoding (KILL, WAIT, RUN), the mode-bit constants (MODE_RD=bit0, MODE_WR=bit1) and the counter width (8).
REQ-031 Sub-module dma_region_match SHALL implement a single region compare (base, size, mode, addr, en, we -> violation) and SHALL be instantiated NUM_REGIONS times by a generate loop.

Verification
REQ-032 Test 1: reset_n released, pc=0 from cycle 0 -> kill_rst=1 for 4 cycles after release, then 0; viol_map=0.
REQ-033 Test 2: RUN, dma_en=1, dma_we=0, dma_addr=16'h0FFF -> kill_rst=1 next cycle, viol_map=2'b01; then addr 16'h1000 -> no violation.
REQ-034 Test 3: RUN, read at 16'hA010 -> no violation (region 1 is write-only); write at 16'hA010 -> viol_map=2'b10, kill_rst=1.
REQ-035 Test 4: violation on KILL cycle 2 -> counter restarts, giving 4 more KILL cycles; pc=0 together with a violation in WAIT -> stays KILL.
REQ-036 Test 5: reset_n pulsed low during RUN -> kill_rst=1 asynchronously, viol_map=0, full hold sequence repeats.
REQ-037 Test 6 (DMA_GUARD_CAPTURE_EN): violations at 16'h0500 then 16'h0600 -> viol_addr=16'h0500; cleared to 0 on entry to RUN.
